// File: rtl/la_pkg.sv
//==============================================================================
// Module      : la_pkg
// Description : Shared types and constants for the logic-analyser read-out.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package la_pkg;

    localparam int AW_DEFAULT = 15;
    localparam int LA_CH      = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_FIN  = 3'd4
    } la_state_t;

    // Beat count for a requested length; zero selects the full ring.
    function automatic logic [AW_DEFAULT:0] beats_for_len(input logic [AW_DEFAULT-1:0] len);
        return (len == '0) ? {1'b1, {AW_DEFAULT{1'b0}}} : {1'b0, len};
    endfunction

endpackage

`default_nettype wire

// File: rtl/la_addr_gen.sv
//==============================================================================
// Module      : la_addr_gen
// Description : Read address and remaining-beat counter with modulo-2^AW step.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module la_addr_gen #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW-1:0] i_len,
    input  logic [2:0]    i_step_log2,
    output logic [AW-1:0] o_rd_addr,
    output logic [AW:0]   o_beats_left
);

    logic [AW-1:0] r_addr;
    logic [AW:0]   r_beats;
    logic [2:0]    r_step_log2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_beats     <= '0;
            r_step_log2 <= '0;
        end else if (i_load) begin
            r_addr      <= i_base_addr;
            r_beats     <= (i_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, i_len};
            r_step_log2 <= i_step_log2;
        end else if (i_step) begin
            // Natural AW-bit overflow gives the ring wrap.
            r_addr  <= r_addr + (AW'(1) << r_step_log2);
            r_beats <= r_beats - (AW+1)'(1);
        end
    end

    assign o_rd_addr    = r_addr;
    assign o_beats_left = r_beats;

endmodule

`default_nettype wire

// File: rtl/la_readout.sv
//==============================================================================
// Module      : la_readout
// Description : Capture-RAM read-out engine producing a valid/ready beat stream.
//               Build option LA_READOUT_EDGE_EN enables per-channel edge flags.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module la_readout
    import la_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = AW_DEFAULT
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW-1:0]    len,
    input  logic [2:0]       step_log2,
    output logic [AW-1:0]    rd_addr,
    input  logic [LA_CH-1:0] rd_data,
    output logic [LA_CH-1:0] out_data,
    output logic [LA_CH-1:0] out_edge,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int c_wait_w = $clog2(RD_LAT + 1);

    la_state_t           r_state;
    logic [c_wait_w-1:0] r_wait;
    logic [LA_CH-1:0]    r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_done;
    logic [AW:0]         w_beats_left;
    logic                w_load;
    logic                w_step;
    logic                w_capture;
    logic                w_final;

    assign w_load    = (r_state == ST_IDLE) && start && !abort;
    assign w_step    = (r_state == ST_HOLD) && r_valid && out_ready && !abort;
    assign w_capture = (r_state == ST_WAIT) && (r_wait == '0) && !abort;
    assign w_final   = (w_beats_left == (AW+1)'(1));

    la_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk          (clk_50M),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_base_addr  (base_addr),
        .i_len        (len),
        .i_step_log2  (step_log2),
        .o_rd_addr    (rd_addr),
        .o_beats_left (w_beats_left)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_busy  <= 1'b1;
                            r_state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        r_wait  <= c_wait_w'(RD_LAT);
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_capture) begin
                            r_data  <= rd_data;
                            r_valid <= 1'b1;
                            r_last  <= w_final;
                            r_state <= ST_HOLD;
                        end else begin
                            r_wait <= r_wait - c_wait_w'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (w_step) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (w_final) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_FIN;
                            end else begin
                                r_state <= ST_ADDR;
                            end
                        end
                    end
                    ST_FIN: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef LA_READOUT_EDGE_EN
    logic [LA_CH-1:0] r_edge;
    logic             r_first;

    // r_data still holds the previous beat when the next word is captured.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_edge  <= '0;
            r_first <= 1'b0;
        end else if (w_load) begin
            r_first <= 1'b1;
        end else if (w_capture) begin
            r_edge  <= r_first ? '0 : (rd_data ^ r_data);
            r_first <= 1'b0;
        end
    end

    assign out_edge = r_edge;
`else
    assign out_edge = '0;
`endif

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_la_readout.sv
//==============================================================================
// Module      : tb_la_readout
// Description : Self-checking bench for la_readout against a behavioural model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_la_readout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [14:0] base_addr = '0, len = '0;
    logic [2:0]  step_log2 = '0;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data, out_data, out_edge;
    logic        out_valid, out_last, busy, done;

    logic        start_s = 1'b0, abort_s = 1'b0, ready_s = 1'b1;
    logic [9:0]  base_s = '0, len_s = '0;
    logic [2:0]  step_s = '0;
    logic [9:0]  rd_addr_s;
    logic [7:0]  rd_data_s, out_data_s, out_edge_s;
    logic        out_valid_s, out_last_s, busy_s, done_s;

    logic [7:0]  mem [0:32767];
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  q_data[$], q_edge[$];
    logic        q_last[$];
    logic [14:0] q_addr[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) rd_data   <= mem[rd_addr];
    always @(posedge clk) rd_data_s <= rd_addr_s[7:0];

    la_readout #(.RD_LAT(1), .AW(15)) dut (
        .clk_50M(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .len(len), .step_log2(step_log2),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_edge(out_edge),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    // Narrow instance so the full-ring (len=0) run stays short.
    la_readout #(.RD_LAT(1), .AW(10)) dut_s (
        .clk_50M(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .base_addr(base_s), .len(len_s), .step_log2(step_s),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s), .out_data(out_data_s), .out_edge(out_edge_s),
        .out_valid(out_valid_s), .out_ready(ready_s), .out_last(out_last_s),
        .busy(busy_s), .done(done_s)
    );

    function automatic logic [14:0] exp_addr(input logic [14:0] b, input logic [2:0] s, input int i);
        return 15'((int'(b) + i * (1 << s)) % 32768);
    endfunction

    function automatic logic [7:0] exp_edge(input logic [14:0] b, input logic [2:0] s, input int i);
`ifdef LA_READOUT_EDGE_EN
        if (i == 0) return 8'h00;
        return mem[exp_addr(b, s, i)] ^ mem[exp_addr(b, s, i - 1)];
`else
        return 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches a run and records every beat; a single stall window may be applied.
    task automatic run_collect(input logic [14:0] b, input logic [14:0] l, input logic [2:0] s,
                               input int stall_beat, input int max_cyc,
                               output bit tmo, output int unstable, output int done_cyc,
                               output bit done_bad, output bit start_ok);
        int cyc, stalls;
        bit held;
        logic [7:0] h_data, h_edge;
        logic h_last;
        q_data.delete(); q_edge.delete(); q_last.delete(); q_addr.delete(); q_cyc.delete();
        base_addr = b; len = l; step_log2 = s; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        start_ok = (busy === 1'b1) && (rd_addr === b);
        base_addr = 15'($urandom); len = 15'($urandom); step_log2 = 3'($urandom);
        cyc = 0; stalls = 0; held = 0; unstable = 0; done_cyc = -1; tmo = 1; done_bad = 0;
        h_data = '0; h_edge = '0; h_last = 1'b0;
        while (cyc < max_cyc) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                tmo = 0;
                done_bad = (busy !== 1'b0) || (out_valid !== 1'b0);
                tick();
                if (done !== 1'b0) done_bad = 1;
                break;
            end
            if (out_valid === 1'b1) begin
                if (held) begin
                    if (out_data !== h_data || out_edge !== h_edge || out_last !== h_last) unstable++;
                end else begin
                    q_data.push_back(out_data); q_edge.push_back(out_edge);
                    q_last.push_back(out_last); q_addr.push_back(rd_addr); q_cyc.push_back(cyc);
                end
                h_data = out_data; h_edge = out_edge; h_last = out_last;
                if (q_data.size() - 1 == stall_beat && stalls < 5) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                end
                held = !out_ready;
            end else begin
                held = 0;
                out_ready = 1'b1;
            end
            start = (cyc == 5);
            tick();
            start = 1'b0;
            cyc++;
        end
        out_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag, input logic [14:0] b, input int n, input logic [2:0] s,
                               input bit tmo, input int unstable, input int done_cyc, input bit done_bad,
                               input bit start_ok);
        checks++;
        if (tmo) begin errors++; $display("FAIL %s_timeout no done within budget", tag); end
        checks++;
        if (!start_ok) begin errors++; $display("FAIL %s_start busy=%b rd_addr=%h exp busy=1 rd_addr=%h", tag, busy, rd_addr, b); end
        checks++;
        if (q_data.size() !== n) begin errors++; $display("FAIL %s_count got %0d exp %0d", tag, q_data.size(), n); end
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            checks++;
            if (q_addr[i] !== exp_addr(b, s, i) || q_data[i] !== mem[exp_addr(b, s, i)] ||
                q_last[i] !== (i == n - 1) || q_edge[i] !== exp_edge(b, s, i)) begin
                errors++;
                $display("FAIL %s_beat%0d got addr=%h data=%h last=%b edge=%h exp addr=%h data=%h last=%b edge=%h",
                         tag, i, q_addr[i], q_data[i], q_last[i], q_edge[i], exp_addr(b, s, i),
                         mem[exp_addr(b, s, i)], (i == n - 1), exp_edge(b, s, i));
            end
        end
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL %s_stable changes=%0d exp 0", tag, unstable); end
        checks++;
        if (!tmo && q_cyc.size() > 0 && (done_cyc !== q_cyc[q_cyc.size()-1] + 1 || done_bad)) begin
            errors++;
            $display("FAIL %s_done cyc=%0d bad=%b exp cyc=%0d bad=0", tag, done_cyc, done_bad, q_cyc[q_cyc.size()-1] + 1);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({rd_addr, out_data, out_edge, out_valid, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h data=%h edge=%h v=%b l=%b busy=%b done=%b exp all 0",
                     rd_addr, out_data, out_edge, out_valid, out_last, busy, done);
        end
    endtask

    task automatic test_basic();
        bit tmo, dbad, sok; int un, dc;
        for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
        run_collect(15'h0010, 15'd4, 3'd0, -1, 40, tmo, un, dc, dbad, sok);
        check_beats("basic", 15'h0010, 4, 3'd0, tmo, un, dc, dbad, sok);
        for (int i = 0; i < q_cyc.size(); i++) begin
            checks++;
            if (q_cyc[i] !== 3 + 4 * i) begin
                errors++;
                $display("FAIL basic_spacing beat%0d cyc=%0d exp %0d", i, q_cyc[i], 3 + 4 * i);
            end
        end
    endtask

    task automatic test_wrap();
        bit tmo, dbad, sok; int un, dc;
        for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
        run_collect(15'h7FFE, 15'd4, 3'd1, -1, 40, tmo, un, dc, dbad, sok);
        check_beats("wrap", 15'h7FFE, 4, 3'd1, tmo, un, dc, dbad, sok);
    endtask

    task automatic test_backpressure();
        bit tmo, dbad, sok; int un, dc;
        logic [14:0] b = 15'($urandom);
        logic [2:0]  s = 3'($urandom);
        run_collect(b, 15'd6, s, 1, 60, tmo, un, dc, dbad, sok);
        check_beats("bp", b, 6, s, tmo, un, dc, dbad, sok);
    endtask

    task automatic test_edge();
        bit tmo, dbad, sok; int un, dc;
        logic [14:0] b = 15'($urandom);
        logic [7:0] words [4] = '{8'h00, 8'h0F, 8'h0F, 8'hF0};
        for (int i = 0; i < 4; i++) mem[exp_addr(b, 3'd0, i)] = words[i];
        run_collect(b, 15'd4, 3'd0, -1, 40, tmo, un, dc, dbad, sok);
        check_beats("edge", b, 4, 3'd0, tmo, un, dc, dbad, sok);
    endtask

    task automatic test_random();
        bit tmo, dbad, sok; int un, dc, n;
        logic [14:0] b; logic [2:0] s;
        for (int r = 0; r < 6; r++) begin
            b = 15'($urandom); s = 3'($urandom); n = $urandom_range(1, 12);
            run_collect(b, 15'(n), s, $urandom_range(0, n), 4 * n + 30, tmo, un, dc, dbad, sok);
            check_beats("rand", b, n, s, tmo, un, dc, dbad, sok);
        end
    endtask

    task automatic test_abort();
        bit tmo, dbad, sok; int un, dc, vcount, cyc, late;
        logic [14:0] b = 15'($urandom);
        logic [2:0]  s = 3'($urandom);
        base_addr = b; len = 15'd10; step_log2 = s; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        vcount = 0; cyc = 0;
        while (vcount < 2 && cyc < 40) begin
            if (out_valid === 1'b1) vcount++;
            if (vcount < 2) begin tick(); cyc++; end
        end
        checks++;
        if (vcount !== 2) begin errors++; $display("FAIL abort_prefix beats=%0d exp 2", vcount); end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== exp_addr(b, s, 2)) begin
            errors++;
            $display("FAIL abort_clear got v=%b busy=%b addr=%h exp v=0 busy=0 addr=%h",
                     out_valid, busy, rd_addr, exp_addr(b, s, 2));
        end
        late = 0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || out_valid !== 1'b0) late++;
            tick();
        end
        checks++;
        if (late !== 0) begin errors++; $display("FAIL abort_quiet activity=%0d exp 0", late); end
        base_addr = 15'(b + 15'd77); start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_addr !== exp_addr(b, s, 2)) begin
            errors++;
            $display("FAIL abort_start_same got busy=%b addr=%h exp busy=0 addr=%h", busy, rd_addr, exp_addr(b, s, 2));
        end
        b = 15'($urandom);
        run_collect(b, 15'd3, s, -1, 40, tmo, un, dc, dbad, sok);
        check_beats("after_abort", b, 3, s, tmo, un, dc, dbad, sok);
    endtask

    task automatic test_reset_mid();
        int cyc;
        base_addr = 15'($urandom) | 15'd1; len = 15'd5; step_log2 = 3'd0; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_hold got v=%b exp 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_addr, out_data, out_edge, out_valid, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got addr=%h data=%h edge=%h v=%b l=%b busy=%b done=%b exp all 0",
                     rd_addr, out_data, out_edge, out_valid, out_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_len0();
        int nb, nlast, last_idx, bad, cyc;
        base_s = '0; len_s = '0; step_s = 3'd7; ready_s = 1'b1; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        nb = 0; nlast = 0; last_idx = -1; bad = 0; cyc = 0;
        while (done_s !== 1'b1 && cyc < 5000) begin
            if (out_valid_s === 1'b1) begin
                if (out_data_s !== 8'((nb * 128) % 1024)) bad++;
                if (out_last_s === 1'b1) begin nlast++; last_idx = nb; end
                nb++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (done_s !== 1'b1) begin errors++; $display("FAIL len0_timeout done=%b exp 1", done_s); end
        checks++;
        if (nb !== 1024) begin errors++; $display("FAIL len0_count got %0d exp 1024", nb); end
        checks++;
        if (nlast !== 1 || last_idx !== 1023) begin
            errors++;
            $display("FAIL len0_last got count=%0d idx=%0d exp count=1 idx=1023", nlast, last_idx);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL len0_data wrong=%0d exp 0", bad); end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
        #23 test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_basic();
        test_wrap();
        test_backpressure();
        test_edge();
        test_random();
        test_abort();
        test_reset_mid();
        test_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
